// File: rtl/booth_multiplier_seq_if.sv
// booth_multiplier_seq_if: start/done handshake, operands and product of the Booth multiplier
interface booth_multiplier_seq_if #(parameter int WIDTH = 4);
  logic                 i_start;
  logic [WIDTH-1:0]     i_multiplicand;
  logic [WIDTH-1:0]     i_multiplier;
  logic                 o_busy;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_product;
  modport master (output i_start, i_multiplicand, i_multiplier, input o_busy, o_done, o_product);
  modport slave  (input i_start, i_multiplicand, i_multiplier, output o_busy, o_done, o_product);
endinterface

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-2 Booth multiplier, one step per clock, start/done handshake
module booth_multiplier_seq #(parameter int WIDTH = 4) (
  input logic i_clk,
  input logic i_rst,
  booth_multiplier_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic signed [WIDTH:0] a_q, a_d, m_ext, sum;
  logic [WIDTH-1:0] m_q, m_d, q_q, q_d;
  logic qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic done_q, done_d;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end
  // A is one bit wider than M so that A - (-2^(W-1)) never overflows
  always_comb begin
    m_ext   = {m_q[WIDTH-1], m_q};
    sum     = (q_q[0] & ~qm1_q) ? a_q - m_ext : (~q_q[0] & qm1_q) ? a_q + m_ext : a_q;
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        m_d     = bus.i_multiplicand;
        q_d     = bus.i_multiplier;
        a_d     = '0;
        qm1_d   = 1'b0;
        cnt_d   = CW'(WIDTH);
        state_d = CALC;
      end
      CALC: begin
        a_d     = {sum[WIDTH], sum[WIDTH:1]};
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? DONE : CALC;
      end
      DONE: begin
        prod_d  = {a_q[WIDTH-1:0], q_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.o_busy    = (state_q == CALC);
  assign bus.o_done    = done_q;
  assign bus.o_product = prod_q;
endmodule
